// File: rtl/tinycpu_pkg.sv
// Widths, fetch state encoding and alignment constant shared by the front-end
// stages (fetch, decode and later).
package tinycpu_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  localparam logic [PC_W-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    WAIT_ACK   = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads a 1-cycle-latency instruction memory and
// holds each word on DOR/data_out until the decoder acks it.
module instruction_fetch
  import tinycpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] PC_STEP  = 32'd4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic              imem_rd_en,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic              DOR,
  output logic [INST_W-1:0] data_out,
  output logic [PC_W-1:0]   pc_out,
  input  logic              ack_from_next,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              err_misaligned,
  output logic [31:0]       fetch_count
);

  fetch_state_t      r_state;
  logic [PC_W-1:0]   r_pc;
  logic              r_dor;
  logic [INST_W-1:0] r_data;
  logic [PC_W-1:0]   r_pc_out;
  logic              r_err;
  logic [31:0]       r_count;

  logic w_accept;
  logic w_misaligned;

  assign w_accept     = (r_state == WAIT_ACK) && ack_from_next;
  assign w_misaligned = (redirect_pc[1:0] != 2'b00);

  // A redirect in FETCH_REQ would make the read stale, so it is not issued.
  assign imem_rd_en = reset && (r_state == FETCH_REQ) && fetch_en && !redirect_valid;
  assign imem_addr  = r_pc;

  assign DOR            = r_dor;
  assign data_out       = r_data;
  assign pc_out         = r_pc_out;
  assign err_misaligned = r_err;
  assign fetch_count    = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= FETCH_REQ;
      r_pc     <= RESET_PC;
      r_dor    <= 1'b0;
      r_data   <= '0;
      r_pc_out <= '0;
      r_err    <= 1'b0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      // The word on DOR still counts if acked in the same cycle; PC takes the target.
      r_pc    <= redirect_pc & WORD_ALIGN_MASK;
      r_dor   <= 1'b0;
      r_state <= FETCH_REQ;
      if (w_misaligned) begin
        r_err <= 1'b1;
      end
      if (w_accept) begin
        r_count <= r_count + 32'd1;
      end
    end else begin
      case (r_state)
        FETCH_REQ: begin
          if (fetch_en) begin
            r_state <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          r_data   <= imem_data;
          r_pc_out <= r_pc;
          r_dor    <= 1'b1;
          r_state  <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack_from_next) begin
            r_dor   <= 1'b0;
            r_pc    <= r_pc + PC_STEP;
            r_count <= r_count + 32'd1;
            r_state <= FETCH_REQ;
          end
        end
        default: begin
          r_dor   <= 1'b0;
          r_state <= FETCH_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios, then random traffic checked by a
// scoreboard fed from a PC-sequence reference model.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        DOR;
  logic [31:0] data_out;
  logic [31:0] pc_out;
  logic        ack_from_next;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        err_misaligned;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;
  int presented = 0;
  bit sb_on = 0;
  logic [31:0] exp_q[$];

  instruction_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .DOR            (DOR),
    .data_out       (data_out),
    .pc_out         (pc_out),
    .ack_from_next  (ack_from_next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .err_misaligned (err_misaligned),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0123_0020;
  endfunction

  // Synchronous memory: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (imem_rd_en) imem_data <= mem_word(imem_addr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Monitor: pops the expected PC whenever a new word appears on DOR.
  initial begin
    logic        prev_dor;
    logic [31:0] hold_d;
    logic [31:0] hold_p;
    logic [31:0] e;
    prev_dor = 1'b0;
    hold_d = '0;
    hold_p = '0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_on) begin
        if (DOR && !prev_dor) begin
          presented++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected actual=%h expected=no_word", pc_out);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", pc_out, e);
            chk("sb_data", data_out, mem_word(e));
          end
          hold_d = data_out;
          hold_p = pc_out;
        end else if (DOR && prev_dor) begin
          chk("sb_hold_data", data_out, hold_d);
          chk("sb_hold_pc", pc_out, hold_p);
        end
      end
      prev_dor = DOR;
    end
  end

  initial begin
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic        m_err;
    logic [31:0] tgt;
    logic        dor_now;
    logic        ack;
    logic        rv;

    reset = 1'b0;
    fetch_en = 1'b1;
    ack_from_next = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clk);

    chk("rst_dor", {31'd0, DOR}, 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_err", {31'd0, err_misaligned}, 32'd0);
    chk("rst_rd_en", {31'd0, imem_rd_en}, 32'd0);

    // First fetch after reset release.
    reset = 1'b1;
    #1;
    chk("t1_rd_en", {31'd0, imem_rd_en}, 32'd1);
    chk("t1_addr", imem_addr, 32'd0);
    @(negedge clk);
    chk("t1_dor_wait", {31'd0, DOR}, 32'd0);
    @(negedge clk);
    chk("t1_dor", {31'd0, DOR}, 32'd1);
    chk("t1_data", data_out, 32'h0123_0020);
    chk("t1_pc_out", pc_out, 32'd0);
    ack_from_next = 1'b1;
    @(negedge clk);
    ack_from_next = 1'b0;
    chk("t1_dor_after_ack", {31'd0, DOR}, 32'd0);
    chk("t1_count", fetch_count, 32'd1);
    chk("t1_next_addr", imem_addr, 32'd4);

    // Decoder holds off its ack for 5 cycles.
    repeat (2) @(negedge clk);
    chk("t2_dor", {31'd0, DOR}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold_dor", {31'd0, DOR}, 32'd1);
      chk("t2_hold_data", data_out, mem_word(32'd4));
      chk("t2_hold_pc", pc_out, 32'd4);
    end
    ack_from_next = 1'b1;
    @(negedge clk);
    ack_from_next = 1'b0;
    chk("t2_count", fetch_count, 32'd2);
    chk("t2_next_addr", imem_addr, 32'd8);

    // Redirect while the read of 0x8 is in flight.
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t3_dor", {31'd0, DOR}, 32'd0);
    chk("t3_addr", imem_addr, 32'h100);
    chk("t3_err", {31'd0, err_misaligned}, 32'd0);
    @(negedge clk);
    chk("t3_no_stale", {31'd0, DOR}, 32'd0);
    @(negedge clk);
    chk("t3_dor_new", {31'd0, DOR}, 32'd1);
    chk("t3_pc_out", pc_out, 32'h100);
    chk("t3_data", data_out, mem_word(32'h100));

    // Misaligned redirect together with ack.
    ack_from_next = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0206;
    @(negedge clk);
    ack_from_next = 1'b0;
    redirect_valid = 1'b0;
    chk("t4_count", fetch_count, 32'd3);
    chk("t4_addr", imem_addr, 32'h204);
    chk("t4_err", {31'd0, err_misaligned}, 32'd1);
    chk("t4_dor", {31'd0, DOR}, 32'd0);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
    repeat (2) @(negedge clk);
    chk("t5_dor", {31'd0, DOR}, 32'd1);
    chk("t5_pc_out", pc_out, 32'hFFFF_FFFC);
    ack_from_next = 1'b1;
    @(negedge clk);
    ack_from_next = 1'b0;
    chk("t5_wrap_addr", imem_addr, 32'd0);
    chk("t5_count", fetch_count, 32'd4);
    chk("t5_err_sticky", {31'd0, err_misaligned}, 32'd1);

    // Stall with fetch_en low.
    fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_rd_en", {31'd0, imem_rd_en}, 32'd0);
      chk("t6_dor", {31'd0, DOR}, 32'd0);
    end
    fetch_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_dor_resume", {31'd0, DOR}, 32'd1);
    chk("t6_pc_out", pc_out, 32'd0);

    // Asynchronous reset while a word is presented.
    #2;
    reset = 1'b0;
    #1;
    chk("t7_dor", {31'd0, DOR}, 32'd0);
    chk("t7_data", data_out, 32'd0);
    chk("t7_count", fetch_count, 32'd0);
    chk("t7_err", {31'd0, err_misaligned}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t7_restart_addr", imem_addr, 32'd0);
    repeat (2) @(negedge clk);
    chk("t7_restart_dor", {31'd0, DOR}, 32'd1);
    chk("t7_restart_pc", pc_out, 32'd0);

    // Random traffic against the PC-sequence model.
    @(negedge clk);
    reset = 1'b0;
    ack_from_next = 1'b0;
    exp_q.delete();
    m_pc = 32'd0;
    m_count = 32'd0;
    m_err = 1'b0;
    exp_q.push_back(m_pc);
    @(negedge clk);
    reset = 1'b1;
    sb_on = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 250 == 0) begin
        chk("rnd_count", fetch_count, m_count);
        chk("rnd_err", {31'd0, err_misaligned}, {31'd0, m_err});
      end
      dor_now = DOR;
      fetch_en = ($urandom_range(0, 9) < 8);
      ack = dor_now ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      rv = ($urandom_range(0, 19) == 0);
      tgt = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 7) == 0) tgt = tgt | 32'hFFFF_F000;
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      ack_from_next = ack;
      redirect_valid = rv;
      redirect_pc = tgt;
      if (ack && dor_now) m_count = m_count + 32'd1;
      if (rv) begin
        if (tgt[1:0] != 2'b00) m_err = 1'b1;
        m_pc = {tgt[31:2], 2'b00};
        exp_q.delete();
        exp_q.push_back(m_pc);
      end else if (ack && dor_now) begin
        m_pc = m_pc + 32'd4;
        exp_q.push_back(m_pc);
      end
    end
    @(negedge clk);
    ack_from_next = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("end_count", fetch_count, m_count);
    chk("end_err", {31'd0, err_misaligned}, {31'd0, m_err});
    chk("end_liveness", {31'd0, presented >= 20}, 32'd1);
    sb_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Upstream producer for the instruction decoder stage on the DIR/DOR/ack handshake.
- Owns the program counter and reads 32-bit words from a synchronous instruction memory with 1-cycle read latency.
- Presents one instruction at a time to the decoder and holds it until the decoder acknowledges it.
- Supports PC redirect (branch/jump) from later stages and a fetch-enable stall input.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset; bits [1:0] must be 0.
PC_STEP, 32'd4, byte increment applied to PC per accepted instruction.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted); deassertion is synchronised externally.
fetch_en  input  1  1 = new memory requests allowed; 0 = stall before issuing the next request.
imem_rd_en  output  1  read strobe to instruction memory; high exactly in FETCH_REQ.
imem_addr  output  32  byte address of the word being read; equals pc.
imem_data  input  32  read data, valid on the cycle after imem_rd_en=1.
DOR  output  1  data output ready to the decoder (decoder DIR).
data_out  output  32  instruction word to the decoder (decoder data_in).
pc_out  output  32  PC of the word on data_out.
ack_from_next  input  1  decoder ack_prev; one-cycle pulse accepting the current word.
redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
redirect_pc  input  32  target byte address.
err_misaligned  output  1  sticky; set when a redirect target has [1:0] != 0.
fetch_count  output  32  number of instructions accepted by the decoder; wraps modulo 2^32.

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH_REQ, pc=RESET_PC, DOR=0, data_out=0, pc_out=0, err_misaligned=0, fetch_count=0. imem_rd_en is 0 while reset is asserted.
- States:
  - FETCH_REQ: imem_rd_en=1 and imem_addr=pc, only when fetch_en=1; advance to FETCH_WAIT. When fetch_en=0: imem_rd_en=0, stay in FETCH_REQ.
  - FETCH_WAIT: capture imem_data into data_out and pc into pc_out; set DOR=1; go to WAIT_ACK.
  - WAIT_ACK: DOR=1; data_out and pc_out held stable. When ack_from_next=1: DOR<=0, pc<=pc+PC_STEP, fetch_count+=1, go to FETCH_REQ. Otherwise stay.
- Latency: a request issued at edge N produces DOR=1 after edge N+1. First DOR=1 appears 2 clocks after reset release with fetch_en=1.
- Throughput: the decoder acks one cycle after it sees DOR, so steady state is 1 instruction per 4 clocks.
- fetch_en is ignored in FETCH_WAIT and WAIT_ACK. An in-flight read always completes and is presented.
- Redirect has priority over all other events in every state:
  - pc <= {redirect_pc[31:2],2'b00}; DOR<=0; state<=FETCH_REQ. Any in-flight memory data is discarded (not presented).
  - If redirect_pc[1:0] != 0, set err_misaligned; it is cleared only by reset.
- Redirect and ack_from_next in the same WAIT_ACK cycle: the word counts as accepted (fetch_count+=1), but pc takes the redirect target, not pc+PC_STEP.
- ack_from_next outside WAIT_ACK is ignored.
- PC arithmetic is 32-bit unsigned: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- Reset asserted mid-operation, including while DOR=1, clears everything immediately. The decoder will not see a completed handshake for the dropped word.
- data_out is never updated while DOR=1.

Decomposition:
- Shared package tinycpu_pkg holds:
  - fetch state encoding (FETCH_REQ, FETCH_WAIT, WAIT_ACK);
  - INST_W=32 and PC_W=32;
  - the word-alignment mask constant.
- The decoder and later stages reuse the package widths.
- No sub-module. PC, counter and FSM live in one module of roughly 150-200 lines.

Test Plan:
- Reset release, fetch_en=1, memory word0=32'h0123_0020: imem_addr=0 with rd_en after edge 1; DOR=1, data_out=32'h0123_0020, pc_out=0 after edge 2; ack pulse at edge 3 -> DOR=0, next imem_addr=4, fetch_count=1.
- Decoder delays ack by 5 cycles: DOR, data_out and pc_out stay constant for all 5 cycles; exactly one increment of pc and fetch_count.
- redirect_valid with redirect_pc=32'h0000_0100 during FETCH_WAIT: the in-flight word is never shown on DOR; next imem_addr=32'h100; err_misaligned=0.
- redirect_pc=32'h0000_0206 concurrent with ack in WAIT_ACK: fetch_count+=1, next imem_addr=32'h204, err_misaligned=1 and it stays 1.
- pc=32'hFFFF_FFFC, ack received: next imem_addr=32'h0000_0000. Separately, fetch_en=0 in FETCH_REQ for 3 cycles: imem_rd_en stays 0 and DOR stays 0.
- reset driven low asynchronously mid-cycle while DOR=1: DOR, data_out and fetch_count are 0 immediately, before the next clk edge; after release, fetch restarts at RESET_PC.
